// File: rtl/rate_ctrl_pkg.sv
// Shared definitions for the 256-bit rate controller and its stream source:
// phase tags, flit geometry, source FSM state codes and the P-derived helpers.
package rate_ctrl_pkg;

   localparam logic [31:0] CONFIG_PHASE   = 32'h0000_00C0;
   localparam logic [31:0] DATA_PHASE     = 32'h0000_005F;
   localparam int          PARAM_SIZE     = 32;
   localparam int          BYTES_PER_FLIT = 32;

   typedef logic [2:0] src_state_t;

   localparam src_state_t ST_IDLE     = 3'd0;
   localparam src_state_t ST_CFG      = 3'd1;
   localparam src_state_t ST_WAIT_ACK = 3'd2;
   localparam src_state_t ST_DATA     = 3'd3;
   localparam src_state_t ST_NULL     = 3'd4;
   localparam src_state_t ST_GAP      = 3'd5;

   // Number of 32-byte flits needed to carry a packet of p bytes.
   function automatic logic [31:0] calc_nflits(input logic [31:0] p);
      return {5'd0, p[31:5]} + {31'd0, |p[4:0]};
   endfunction

   // Valid bytes in the final flit of a packet of p bytes (a full flit when p is a multiple of 32).
   function automatic logic [5:0] calc_last_bytes(input logic [31:0] p);
      return (p[4:0] == 5'd0) ? 6'd32 : {1'b0, p[4:0]};
   endfunction

endpackage

// File: rtl/flit_mask_gen.sv
// Turns a valid-byte count into a byte strobe and the matching 256-bit data mask.
// Purely combinational so the checker side can reuse it unchanged.
module flit_mask_gen
   import rate_ctrl_pkg::*;
(
   input  logic [5:0]   last_bytes,
   output logic [31:0]  strb_mask,
   output logic [255:0] data_mask
);

   // Byte i is kept when it lies below the valid-byte count; each strobe bit fans out to its 8 data bits.
   always_comb begin
      strb_mask = '0;
      data_mask = '0;
      for (int i = 0; i < BYTES_PER_FLIT; i++) begin
         strb_mask[i]       = (last_bytes > 6'(i));
         data_mask[i*8 +: 8] = {8{strb_mask[i]}};
      end
   end

endmodule

// File: rtl/rate_stream_source.sv
// Tagged-stream traffic source for the 256-bit rate controller: sends one config
// flit, waits for the controller's null acknowledge, then emits the configured
// number of P-byte packets, each closed by a null flit and followed by D idle cycles.
module rate_stream_source
   import rate_ctrl_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 256
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [PARAM_SIZE-1:0]         cfg_d,
   input  logic [PARAM_SIZE-1:0]         cfg_n,
   input  logic [PARAM_SIZE-1:0]         cfg_p,
   input  logic [PARAM_SIZE-1:0]         cfg_q,
   input  logic [PARAM_SIZE-1:0]         cfg_f,
   input  logic [15:0]                   cfg_num_pkts,
   input  logic                          out_tready,
   output logic                          out_tvalid,
   output logic [C_AXIS_TDATA_WIDTH-1:0] out_tdata,
   output logic [127:0]                  out_tuser,
   output logic [31:0]                   out_tstrb,
   output logic                          out_tlast,
   output logic [31:0]                   out_tag,
   input  logic                          rsp_tvalid,
   input  logic                          rsp_tlast,
   input  logic [31:0]                   rsp_tag,
   output logic                          rsp_tready,
   output logic                          busy,
   output logic                          done
);

   localparam int LANES = C_AXIS_TDATA_WIDTH / PARAM_SIZE;

   src_state_t  state;
   logic [31:0] d_reg;
   logic [15:0] num_reg;
   logic [31:0] nflits;
   logic [5:0]  last_bytes;
   logic [15:0] pkt_cnt;
   logic [31:0] flit_cnt;
   logic [31:0] gap_cnt;

   logic [15:0] nxt_pkt;
   logic [31:0] nxt_flit;
   logic        nxt_is_last;
   logic [C_AXIS_TDATA_WIDTH-1:0] lane_raw;
   logic [C_AXIS_TDATA_WIDTH-1:0] data_tdata;
   logic [127:0] data_tuser;
   logic [31:0]  data_tstrb;

   logic [31:0]  mask_strb;
   logic [255:0] mask_data;

   logic accept;
   logic ack_beat;

   assign accept   = out_tvalid & out_tready;
   assign ack_beat = rsp_tvalid & rsp_tready & rsp_tlast & (rsp_tag == 32'd0);

   flit_mask_gen u_mask (
      .last_bytes (last_bytes),
      .strb_mask  (mask_strb),
      .data_mask  (mask_data)
   );

   // Pick which packet/flit index the next data flit carries, depending on where the FSM is leaving from.
   always_comb begin
      nxt_pkt  = pkt_cnt;
      nxt_flit = '0;
      case (state)
         ST_DATA: nxt_flit = flit_cnt + 32'd1;
         ST_NULL: nxt_pkt  = pkt_cnt + 16'd1;
         default: ;
      endcase
   end

   // Build the next data flit; the packet's final flit gets the partial strobe and zeroed tail bytes.
   always_comb begin
      nxt_is_last = (nxt_flit == nflits - 32'd1);
      lane_raw    = {LANES{nxt_pkt, nxt_flit[15:0]}};
      data_tdata  = lane_raw;
      data_tuser  = 128'd32;
      data_tstrb  = '1;
      if (nxt_is_last) begin
         data_tdata = lane_raw & mask_data;
         data_tuser = {122'd0, last_bytes};
         data_tstrb = mask_strb;
      end
   end

   // Main sequencer; every output is registered and only changes on an accept or an internal step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         d_reg      <= '0;
         num_reg    <= '0;
         nflits     <= '0;
         last_bytes <= '0;
         pkt_cnt    <= '0;
         flit_cnt   <= '0;
         gap_cnt    <= '0;
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
         out_tuser  <= '0;
         out_tstrb  <= '0;
         out_tlast  <= 1'b0;
         out_tag    <= '0;
         rsp_tready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  d_reg      <= cfg_d;
                  num_reg    <= cfg_num_pkts;
                  nflits     <= calc_nflits(cfg_p);
                  last_bytes <= calc_last_bytes(cfg_p);
                  pkt_cnt    <= '0;
                  flit_cnt   <= '0;
                  out_tvalid <= 1'b1;
                  out_tdata  <= {96'd0, cfg_f, cfg_q, cfg_p, cfg_n, cfg_d};
                  out_tuser  <= 128'd20;
                  out_tstrb  <= 32'h000F_FFFF;
                  out_tlast  <= 1'b1;
                  out_tag    <= CONFIG_PHASE;
                  busy       <= 1'b1;
                  state      <= ST_CFG;
               end
            end
            ST_CFG: begin
               if (accept) begin
                  out_tvalid <= 1'b0;
                  out_tdata  <= '0;
                  out_tuser  <= '0;
                  out_tstrb  <= '0;
                  out_tlast  <= 1'b0;
                  out_tag    <= '0;
                  rsp_tready <= 1'b1;
                  state      <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (ack_beat) begin
                  rsp_tready <= 1'b0;
                  if (nflits == 32'd0 || num_reg == 16'd0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     out_tvalid <= 1'b1;
                     out_tdata  <= data_tdata;
                     out_tuser  <= data_tuser;
                     out_tstrb  <= data_tstrb;
                     out_tlast  <= nxt_is_last;
                     out_tag    <= DATA_PHASE;
                     state      <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  if (flit_cnt == nflits - 32'd1) begin
                     flit_cnt  <= '0;
                     out_tdata <= '0;
                     out_tuser <= '0;
                     out_tstrb <= '0;
                     out_tlast <= 1'b1;
                     out_tag   <= '0;
                     state     <= ST_NULL;
                  end else begin
                     flit_cnt  <= nxt_flit;
                     out_tdata <= data_tdata;
                     out_tuser <= data_tuser;
                     out_tstrb <= data_tstrb;
                     out_tlast <= nxt_is_last;
                  end
               end
            end
            ST_NULL: begin
               if (accept) begin
                  pkt_cnt <= nxt_pkt;
                  if (nxt_pkt == num_reg) begin
                     out_tvalid <= 1'b0;
                     out_tlast  <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= ST_IDLE;
                  end else if (d_reg == 32'd0) begin
                     out_tdata <= data_tdata;
                     out_tuser <= data_tuser;
                     out_tstrb <= data_tstrb;
                     out_tlast <= nxt_is_last;
                     out_tag   <= DATA_PHASE;
                     state     <= ST_DATA;
                  end else begin
                     gap_cnt    <= d_reg;
                     out_tvalid <= 1'b0;
                     out_tlast  <= 1'b0;
                     state      <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt <= 32'd1) begin
                  out_tvalid <= 1'b1;
                  out_tdata  <= data_tdata;
                  out_tuser  <= data_tuser;
                  out_tstrb  <= data_tstrb;
                  out_tlast  <= nxt_is_last;
                  out_tag    <= DATA_PHASE;
                  state      <= ST_DATA;
               end else begin
                  gap_cnt <= gap_cnt - 32'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rate_stream_source.sv
// Self-checking bench for rate_stream_source. Each run builds the full expected
// flit sequence from the run parameters, plays the controller's return stream,
// and checks accepted flits, stall stability, gap/latency timing, done and reset.
module tb_rate_stream_source;

   logic         clk;
   logic         reset;
   logic         start;
   logic [31:0]  cfg_d, cfg_n, cfg_p, cfg_q, cfg_f;
   logic [15:0]  cfg_num_pkts;
   logic         out_tready;
   logic         out_tvalid;
   logic [255:0] out_tdata;
   logic [127:0] out_tuser;
   logic [31:0]  out_tstrb;
   logic         out_tlast;
   logic [31:0]  out_tag;
   logic         rsp_tvalid;
   logic         rsp_tlast;
   logic [31:0]  rsp_tag;
   logic         rsp_tready;
   logic         busy;
   logic         done;

   typedef struct packed {
      logic [255:0] data;
      logic [127:0] user;
      logic [31:0]  strb;
      logic         last;
      logic [31:0]  tag;
   } flit_t;

   flit_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   rate_stream_source #(.C_AXIS_TDATA_WIDTH(256)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cfg_d        (cfg_d),
      .cfg_n        (cfg_n),
      .cfg_p        (cfg_p),
      .cfg_q        (cfg_q),
      .cfg_f        (cfg_f),
      .cfg_num_pkts (cfg_num_pkts),
      .out_tready   (out_tready),
      .out_tvalid   (out_tvalid),
      .out_tdata    (out_tdata),
      .out_tuser    (out_tuser),
      .out_tstrb    (out_tstrb),
      .out_tlast    (out_tlast),
      .out_tag      (out_tag),
      .rsp_tvalid   (rsp_tvalid),
      .rsp_tlast    (rsp_tlast),
      .rsp_tag      (rsp_tag),
      .rsp_tready   (rsp_tready),
      .busy         (busy),
      .done         (done)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [448:0] got, input logic [448:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      check_output(name, {448'd0, got}, {448'd0, exp});
   endtask

   // One data flit from first principles: every 32-bit lane holds {packet, flit}, bytes past the count are zero.
   function automatic flit_t make_data(input int pk, input int fl, input int bytes, input bit last);
      flit_t       r;
      logic [31:0] word;
      r    = '0;
      word = {16'(pk), 16'(fl)};
      for (int b = 0; b < 32; b++) begin
         if (b < bytes) begin
            r.data[b*8 +: 8] = word[(b % 4)*8 +: 8];
            r.strb[b]        = 1'b1;
         end
      end
      r.user = 128'(bytes);
      r.last = last;
      r.tag  = 32'h5F;
      return r;
   endfunction

   // Expected accepted-flit sequence for a whole run.
   task automatic build_run(input logic [31:0] d, n, p, q, f, input logic [15:0] num);
      flit_t c;
      flit_t z;
      int    pi;
      int    nf;
      exp_q.delete();
      c      = '0;
      c.data = {96'd0, f, q, p, n, d};
      c.user = 128'd20;
      c.strb = 32'h000F_FFFF;
      c.last = 1'b1;
      c.tag  = 32'hC0;
      exp_q.push_back(c);
      pi = int'(p);
      if (pi != 0 && num != 0) begin
         nf = (pi + 31) / 32;
         for (int pk = 0; pk < int'(num); pk++) begin
            for (int fl = 0; fl < nf; fl++)
               exp_q.push_back(make_data(pk, fl, (fl == nf - 1) ? pi - 32*fl : 32, fl == nf - 1));
            z      = '0;
            z.last = 1'b1;
            exp_q.push_back(z);
         end
      end
   endtask

   // Run one configuration; mode 0 = tready high, 1 = toggling, 2 = random. abort_second resets on packet 0 flit 1.
   task automatic apply_stimulus(input logic [31:0] d, input logic [31:0] p, input logic [15:0] num,
                                 input int mode, input int n_junk, input bit abort_second);
      flit_t       got, prev, exp_f;
      logic [31:0] n, q, f;
      bit          waiting, prev_stall, exp_valid, exp_done, finished, aborted, run_empty;
      int          exp_idle, junk_sent, data_seen, cyc;
      waiting = 0; prev_stall = 0; exp_valid = 1; exp_done = 0; finished = 0; aborted = 0;
      exp_idle = 0; junk_sent = 0; data_seen = 0; cyc = 0;
      prev = '0;
      run_empty = (p == 0) || (num == 0);
      n = $urandom; q = $urandom; f = $urandom;
      build_run(d, n, p, q, f, num);
      $display("[TB] run D=%0d P=%0d pkts=%0d mode=%0d junk=%0d abort=%0d", d, p, num, mode, n_junk, abort_second);
      cfg_d = d; cfg_n = n; cfg_p = p; cfg_q = q; cfg_f = f; cfg_num_pkts = num;
      start = 1'b1; out_tready = 1'b1; rsp_tvalid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_d = $urandom; cfg_n = $urandom; cfg_p = $urandom; cfg_q = $urandom; cfg_f = $urandom;
      cfg_num_pkts = 16'($urandom);
      while (!finished && !aborted && cyc < 2000) begin
         got = {out_tdata, out_tuser, out_tstrb, out_tlast, out_tag};
         if (exp_done) begin
            check_output("done_state", {446'd0, done, busy, out_tvalid}, {446'd0, 3'b100});
            finished = 1;
         end else begin
            check_bit("done_low", done, 1'b0);
            check_bit("busy_high", busy, 1'b1);
            if (prev_stall) check_output("stall_hold", got, prev);
            if (exp_valid) begin
               check_bit("valid_latency", out_tvalid, 1'b1);
               exp_valid = 0;
            end else if (exp_idle > 0) begin
               check_bit("gap_idle", out_tvalid, 1'b0);
               exp_idle--;
               if (exp_idle == 0) exp_valid = 1;
            end
            check_bit("rsp_tready", rsp_tready, waiting);
            if (abort_second && data_seen == 1 && out_tvalid && out_tag == 32'h5F) begin
               aborted = 1;
            end else begin
               case (mode)
                  0:       out_tready = 1'b1;
                  1:       out_tready = ~out_tready;
                  default: out_tready = 1'($urandom % 2);
               endcase
               start = ($urandom % 4 == 0);
               if (waiting) begin
                  rsp_tvalid = ($urandom % 4 != 0);
                  if (junk_sent < n_junk) begin
                     rsp_tag  = (junk_sent % 2 == 1) ? 32'h0 : 32'h5F;
                     rsp_tlast = (junk_sent % 2 == 1) ? 1'b0 : 1'b1;
                  end else begin
                     rsp_tag  = 32'h0;
                     rsp_tlast = 1'b1;
                  end
                  if (rsp_tvalid) begin
                     if (junk_sent < n_junk) junk_sent++;
                     else begin
                        waiting = 0;
                        if (run_empty) exp_done = 1;
                        else exp_valid = 1;
                     end
                  end
               end else begin
                  rsp_tvalid = 1'($urandom % 2);
                  rsp_tag    = 32'h0;
                  rsp_tlast  = 1'b1;
               end
               if (out_tvalid && out_tready) begin
                  if (exp_q.size() == 0) begin
                     check_output("extra_flit", got, '0);
                  end else begin
                     exp_f = exp_q.pop_front();
                     check_output("flit", got, exp_f);
                     if (exp_f.tag == 32'hC0) waiting = 1;
                     else if (exp_f.tag == 32'h5F) begin
                        exp_valid = 1;
                        data_seen++;
                     end else if (exp_q.size() == 0) exp_done = 1;
                     else if (d == 0) exp_valid = 1;
                     else exp_idle = int'(d);
                  end
               end
               prev_stall = out_tvalid && !out_tready;
               prev = got;
               @(posedge clk); #1;
               cyc++;
            end
         end
      end
      start = 1'b0;
      rsp_tvalid = 1'b0;
      if (aborted) begin
         reset = 1'b1;
         #1;
         check_output("reset_outputs",
                      {out_tvalid, out_tdata, out_tuser, out_tstrb, out_tlast, out_tag, rsp_tready, busy, done},
                      '0);
         out_tready = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         exp_q.delete();
      end else begin
         check_output("run_complete", {447'd0, finished, exp_q.size() == 0}, {447'd0, 2'b11});
      end
      @(posedge clk); #1;
   endtask

   // Directed scenarios followed by a handful of randomized runs.
   initial begin
      reset = 1'b1; start = 1'b0; out_tready = 1'b0;
      cfg_d = '0; cfg_n = '0; cfg_p = '0; cfg_q = '0; cfg_f = '0; cfg_num_pkts = '0;
      rsp_tvalid = 1'b0; rsp_tlast = 1'b0; rsp_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_state",
                   {out_tvalid, out_tdata, out_tuser, out_tstrb, out_tlast, out_tag, rsp_tready, busy, done},
                   '0);
      reset = 1'b0;
      @(posedge clk); #1;

      apply_stimulus(32'd0, 32'd64,  16'd2, 0, 0, 1'b0);
      apply_stimulus(32'd3, 32'd40,  16'd2, 0, 0, 1'b0);
      apply_stimulus(32'd1, 32'd100, 16'd2, 1, 0, 1'b0);
      apply_stimulus(32'd0, 32'd32,  16'd1, 0, 3, 1'b0);
      apply_stimulus(32'd2, 32'd0,   16'd3, 0, 1, 1'b0);
      apply_stimulus(32'd0, 32'd50,  16'd0, 1, 0, 1'b0);
      apply_stimulus(32'd0, 32'd96,  16'd2, 0, 0, 1'b1);
      apply_stimulus(32'd2, 32'd20,  16'd2, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++)
         apply_stimulus($urandom_range(0, 4), $urandom_range(1, 150), 16'($urandom_range(1, 3)),
                        2, $urandom_range(0, 2), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rate_stream_source.md
# rate_stream_source

Tagged-stream transmitter that drives the input of the 256-bit rate controller. On `start` it emits one config flit carrying the D/N/P/Q/F words and waits for the controller's null-flit acknowledge. It then sends `cfg_num_pkts` data packets of P bytes each, closing every packet with a null flit and spacing packets by D idle cycles. It is the stimulus and traffic end of the same AXI-Stream-plus-tag protocol, used in the UDP-parser test harness.

## Interface
- `C_AXIS_TDATA_WIDTH`, 256, data width. Only 256 is supported; the byte count per flit is fixed at 32.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run. Sampled only in IDLE.
- `cfg_d`, `cfg_n`, `cfg_p`, `cfg_q`, `cfg_f`  in  32 each  run parameters, latched on `start`.
- `cfg_num_pkts`  in  16  number of data packets to send; latched on `start`.
- `out_tready`  in  1  downstream ready.
- `out_tvalid`  out  1  flit valid.
- `out_tdata`  out  256  flit data.
- `out_tuser`  out  128  valid-byte count of the flit.
- `out_tstrb`  out  32  byte strobe.
- `out_tlast`  out  1  last flit of a packet.
- `out_tag`  out  32  phase tag.
- `rsp_tvalid`  in  1  return stream from the controller output.
- `rsp_tlast`  in  1  return stream last.
- `rsp_tag`  in  32  return stream tag.
- `rsp_tready`  out  1  return stream ready.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on entry to IDLE from the run.

## Operation
- States: IDLE, CFG, WAIT_ACK, DATA, NULL, GAP.
- **IDLE**
  - On `start`: latch the cfg inputs and go to CFG. Clear `pkt_cnt` and `flit_cnt`.
  - Also compute `nflits = (P>>5) + (P[4:0]!=0)` and `last_bytes = (P[4:0]==0) ? 32 : P[4:0]`.
- **CFG**: present the config flit.
  - `tdata[31:0]`=D, `[63:32]`=N, `[95:64]`=P, `[127:96]`=Q, `[159:128]`=F; all other bits 0.
  - `tag`=0xC0, `tlast`=1, `tstrb`=0x000F_FFFF, `tuser`=20.
  - On accept (`tvalid & tready`), go to WAIT_ACK.
- **WAIT_ACK**: `rsp_tready`=1.
  - Wait for a return beat with `rsp_tvalid & rsp_tlast & rsp_tag==0`.
  - Then go to DATA, or straight to IDLE with `done` if `nflits==0` or `cfg_num_pkts==0`.
  - All other return beats are consumed and ignored.
  - `rsp_tready`=0 in every other state.
- **DATA**: flit `flit_cnt` of packet `pkt_cnt`.
  - `tag`=0x5F.
  - Each 32-bit lane k carries `{pkt_cnt[15:0], flit_cnt[15:0]}`.
  - Non-last flits: `tstrb`=all ones, `tuser`=32, `tlast`=0.
  - Last flit (`flit_cnt==nflits-1`): `tstrb` = low `last_bytes` bits set, `tuser`=`last_bytes`, `tdata` bytes ≥ `last_bytes` forced to 0, `tlast`=1.
  - Advance `flit_cnt` on accept. After the last flit, clear `flit_cnt` and go to NULL.
- **NULL**: null flit with `tag`=0, `tlast`=1, tdata/tstrb/tuser all 0.
  - On accept, increment `pkt_cnt`.
  - If `pkt_cnt+1 == cfg_num_pkts`: go to IDLE and pulse `done`.
  - Else if D==0: go to DATA.
  - Else: load `gap_cnt`=D and go to GAP.
- **GAP**: `tvalid`=0. Decrement `gap_cnt`; at 1, go to DATA.
- `start` outside IDLE is ignored. The cfg inputs may change freely after `start`.

## Timing
- Reset, asynchronous: state=IDLE; all outputs 0 (`tvalid`, `tdata`, `tuser`, `tstrb`, `tlast`, `tag`, `rsp_tready`, `busy`, `done`). Counters are cleared.
- Reset mid-packet abandons the packet immediately with no null flit.
- All `out_*` signals are registered.
  - While `tvalid & !tready`, every output holds stable.
  - `tvalid` never drops without an accept.
- Latencies:
  - `start` at cycle t: config flit valid at t+1.
  - Ack beat accepted at t: first data flit valid at t+1.
  - Null flit accepted at t: next data flit valid at t+1+D.
- Back-to-back accepts give one flit per cycle with no bubbles inside a packet.
- P<32 gives a one-flit packet that has both partial strobe and `tlast`.
- P a multiple of 32 gives a full last flit.
- `pkt_cnt` is 16 bits and never wraps, because it is bounded by `cfg_num_pkts`.

## Structure
- A shared package `rate_ctrl_pkg` holds the tag constants CONFIG_PHASE=0xC0 and DATA_PHASE=0x5F, plus PARAM_SIZE=32, BYTES_PER_FLIT=32, and the state enum.
- The same package is imported by the rate controller.
- One sub-module, `flit_mask_gen`: `last_bytes` in, `tstrb` and 256-bit data mask out. It is combinational and shared with the checker.

## Test plan
- P=64, D=0, N=1, F=64, num_pkts=2, `tready` always high:
  - config flit with tag 0xC0;
  - after ack, flits with tuser 32,32, then null, then 32,32, then null;
  - `done` pulse one cycle after the last null.
- P=40, D=3, num_pkts=2:
  - each packet ends with a last flit of tuser=8, tstrb=0xFF, upper 24 bytes zero;
  - exactly 3 idle cycles between null accept and the next packet.
- `tready` toggling 1010… in DATA: no output change while stalled, and flit indices stay contiguous.
- Return stream sends tag 0x5F beats before the null ack: the source stays in WAIT_ACK and starts data only after the tag 0, tlast 1 beat.
- P=0 or num_pkts=0: config flit, ack, then `done` with no data flits.
- Reset asserted on the second flit of a packet: all outputs 0 that same cycle; a new `start` produces a fresh config flit with `pkt_cnt`=0.
